// File: rtl/fetch_stage_if.sv
// IF-stage bundle: imem read port, decode control inputs and the IF/ID register outputs.
// The fetch stage connects through master, the imem/decode side through slave.
interface fetch_stage_if #(
    parameter int WORD_W = 32
);
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              stall;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
    logic              valid;

    modport master (
        input  ihit, imemload, stall, redirect, redirect_pc, halt,
        output imemREN, imemaddr, instr, npc, valid
    );

    modport slave (
        output ihit, imemload, stall, redirect, redirect_pc, halt,
        input  imemREN, imemaddr, instr, npc, valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads imem, and feeds decode through an
// output register backed by a one-entry skid buffer. Handles redirect and halt.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master fif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);
    localparam logic [WORD_W-1:0] PC_RESET   = PC_INIT & ALIGN_MASK;

    state_t            state,     state_nxt;
    logic [WORD_W-1:0] pc,        pc_nxt;
    logic [WORD_W-1:0] out_instr, instr_nxt;
    logic [WORD_W-1:0] out_npc,   npc_nxt;
    logic              out_valid, valid_nxt;
    logic              skid_full, skid_full_nxt;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_npc;
    logic              load_skid;

    logic [WORD_W-1:0] pc_plus4;
    logic              accept;
    logic              consume;

    assign pc_plus4 = pc + WORD_W'(4);
    assign consume  = out_valid && !fif.stall;
    assign accept   = fif.imemREN && fif.ihit;

    assign fif.imemREN  = (state == ST_RUN) && !skid_full && !fif.redirect && !fif.halt;
    assign fif.imemaddr = pc;
    assign fif.instr    = out_instr;
    assign fif.npc      = out_npc;
    assign fif.valid    = out_valid;

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = out_instr;
        npc_nxt       = out_npc;
        valid_nxt     = out_valid;
        skid_full_nxt = skid_full;
        load_skid     = 1'b0;

        if (state == ST_RUN) begin
            if (fif.halt) begin
                state_nxt     = ST_HALT;
                valid_nxt     = 1'b0;
                instr_nxt     = '0;
                skid_full_nxt = 1'b0;
            end else if (fif.redirect) begin
                // Any word returned this cycle is dropped; fetch restarts at the target.
                pc_nxt        = fif.redirect_pc & ALIGN_MASK;
                valid_nxt     = 1'b0;
                instr_nxt     = '0;
                skid_full_nxt = 1'b0;
            end else begin
                if (accept) begin
                    pc_nxt = pc_plus4;
                end

                if (skid_full && consume) begin
                    instr_nxt     = skid_instr;
                    npc_nxt       = skid_npc;
                    valid_nxt     = 1'b1;
                    skid_full_nxt = 1'b0;
                end else if (accept && (!out_valid || consume)) begin
                    instr_nxt = fif.imemload;
                    npc_nxt   = pc_plus4;
                    valid_nxt = 1'b1;
                end else if (accept) begin
                    // Output is stalled: park the word; imemREN drops until it drains.
                    load_skid     = 1'b1;
                    skid_full_nxt = 1'b1;
                end else if (consume) begin
                    valid_nxt = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_RUN;
            pc        <= PC_RESET;
            out_instr <= '0;
            out_npc   <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            out_instr <= instr_nxt;
            out_npc   <= npc_nxt;
            out_valid <= valid_nxt;
            skid_full <= skid_full_nxt;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while skid_full is set.
    always_ff @(posedge CLK) begin
        if (load_skid) begin
            skid_instr <= fif.imemload;
            skid_npc   <= pc_plus4;
        end
    end

endmodule
